// File: rtl/addsub_seq_ctrl.sv
// rtl/addsub_seq_ctrl.sv - signed WIDTH-bit add/subtract sequenced over a SLICE-bit adder.
// One slice per clock, LSB first, with a registered inter-slice carry.
module addsub_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry_out,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = $clog2(NSLICE) + 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("addsub_seq_ctrl: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q, res_q, res_nxt;
  logic [CW-1:0]     cnt_q;
  logic              carry_q, ovf_q, co_q;
  logic [SLICE-1:0]  sa, sb, s;
  logic              c, c_msb_in;

  // Operands shift right one slice per cycle so the adder always sees bits [SLICE-1:0].
  assign sa = a_q[SLICE-1:0];
  assign sb = b_q[SLICE-1:0];
  assign {c, s} = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, carry_q};
  assign c_msb_in = s[SLICE-1] ^ sa[SLICE-1] ^ sb[SLICE-1];

  // Result fills from the top; after NSLICE shifts each slice sits in place.
  if (NSLICE == 1) begin : g_single
    assign res_nxt = s;
  end else begin : g_multi
    assign res_nxt = {s, res_q[WIDTH-1:SLICE]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (cnt_q == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{op_sub}};
            carry_q <= op_sub;
            cnt_q   <= '0;
            res_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          res_q   <= res_nxt;
          carry_q <= c;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            ovf_q <= c_msb_in ^ c;
            co_q  <= c;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign carry_out = co_q;

endmodule
